dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 149 ++++++++++++++
 tb/tb_dmem_responder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-addressed 16-bit data memory responder with a req/ack handshake and error
// reporting for misaligned or out-of-range accesses. Define DMEM_WAIT_EN to insert
// WAIT_CYCLES wait states before every response.
module dmem_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned DEPTH       = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 16;
    localparam int unsigned IW = 10;
`ifdef DMEM_WAIT_EN
    localparam int unsigned CW = 4;
`endif

    // The wait counter is 4 bits wide; larger settings are a configuration error.
    if (WAIT_CYCLES > 15) begin : g_wait_range
        $error("dmem_responder: WAIT_CYCLES must be 0..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef DMEM_WAIT_EN
        WAIT = 2'd1,
`endif
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_d;
    logic            ack_d, err_d, busy_d;
    logic            mem_we_c;
    logic [IW-1:0]   idx_c;
    logic            acc_err_c;
`ifdef DMEM_WAIT_EN
    logic [CW-1:0]   cnt_q, cnt_d;
`endif

    logic [DW-1:0]   mem [DEPTH];

    // Decode uses only the values captured at acceptance.
    assign idx_c     = addr_q[10:1];
    assign acc_err_c = addr_q[0] | (|addr_q[15:11]);

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        busy_d   = busy;
        mem_we_c = 1'b0;
`ifdef DMEM_WAIT_EN
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    busy_d  = 1'b1;
`ifdef DMEM_WAIT_EN
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CW'(WAIT_CYCLES);
                    end else begin
                        state_d = RESP;
                    end
`else
                    state_d = RESP;
`endif
                end
            end
`ifdef DMEM_WAIT_EN
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = RESP;
                end
            end
`endif
            RESP: begin
                state_d = IDLE;
                ack_d   = 1'b1;
                err_d   = acc_err_c;
                busy_d  = 1'b0;
                if (we_q) begin
                    mem_we_c = ~acc_err_c;
                end else begin
                    rdata_d = acc_err_c ? DW'(0) : mem[idx_c];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            ack     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
`ifdef DMEM_WAIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata   <= rdata_d;
            ack     <= ack_d;
            err     <= err_d;
            busy    <= busy_d;
`ifdef DMEM_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Storage is deliberately not reset; writes only happen from RESP.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[idx_c] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder; latency expectations follow DMEM_WAIT_EN.
module tb_dmem_responder;

    localparam int unsigned WC = 3;
`ifdef DMEM_WAIT_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ack;
    logic        err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    dmem_responder #(.WAIT_CYCLES(WC), .DEPTH(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ack   (ack),
        .err   (err),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where ack is visible.
    task automatic txn(input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic exp_err, input logic [15:0] exp_rd,
                       input string tag, input bit hold, input bit scramble);
        int  lat;
        int  busy_n;
        bit  got;
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        got = 1'b0; busy_n = 0; lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (scramble) begin
                addr = ~a; wdata = ~d; we = ~w;
            end
            if (ack) begin
                got = 1'b1;
                lat = i;
                break;
            end
            if (busy) busy_n++;
            @(posedge clk);
        end
        check({tag, "_ack_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(LAT + 1));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(LAT + 1));
        check({tag, "_busy_at_ack"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_rdata"}, 32'(rdata), 32'(exp_rd));
        we = w; addr = a; wdata = d;
        if (!hold) begin
            req = 1'b0;
            @(negedge clk);
            check({tag, "_ack_pulse"}, {31'd0, ack}, 32'd0);
            check({tag, "_err_idle"}, {31'd0, err}, 32'd0);
        end
    endtask

    initial begin
        int no_ack;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic store then load
        txn(1'b1, 16'h0004, 16'h1234, 1'b0, 16'h0000, "st_0004", 1'b0, 1'b0);
        txn(1'b0, 16'h0004, 16'h0000, 1'b0, 16'h1234, "ld_0004", 1'b0, 1'b0);

        // Errored load zeroes rdata; errored store must not touch index 0
        txn(1'b1, 16'h0000, 16'h5A5A, 1'b0, 16'h1234, "st_0000", 1'b0, 1'b0);
        txn(1'b0, 16'h0003, 16'h0000, 1'b1, 16'h0000, "ld_misal", 1'b0, 1'b0);
        txn(1'b1, 16'h0800, 16'hBEEF, 1'b1, 16'h0000, "st_oor", 1'b0, 1'b0);
        txn(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h5A5A, "ld_0000", 1'b0, 1'b0);

        // Highest valid word
        txn(1'b1, 16'h07FE, 16'h0F0F, 1'b0, 16'h5A5A, "st_top", 1'b0, 1'b0);
        txn(1'b0, 16'h07FE, 16'h0000, 1'b0, 16'h0F0F, "ld_top", 1'b0, 1'b0);

        // Back-to-back with req held high
        txn(1'b1, 16'h0010, 16'hCAFE, 1'b0, 16'h0F0F, "b2b_st", 1'b1, 1'b0);
        txn(1'b0, 16'h0010, 16'h0000, 1'b0, 16'hCAFE, "b2b_ld", 1'b0, 1'b0);

        // Inputs changed after acceptance are ignored
        txn(1'b1, 16'h0020, 16'h7777, 1'b0, 16'hCAFE, "scr_st", 1'b0, 1'b1);
        txn(1'b0, 16'h0004, 16'h0000, 1'b0, 16'h1234, "scr_ld", 1'b0, 1'b1);
        txn(1'b0, 16'h0020, 16'h0000, 1'b0, 16'h7777, "scr_chk", 1'b0, 1'b0);

        // Reset during a pending store to index 5
        txn(1'b1, 16'h000A, 16'h5555, 1'b0, 16'h7777, "pre_idx5", 1'b0, 1'b0);
        req = 1'b1; we = 1'b1; addr = 16'h000A; wdata = 16'hAAAA;
        @(posedge clk);
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rdata", 32'(rdata), 32'h0);
        check("mid_rst_ack", 32'(ack), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        req = 1'b0;
        rst_n = 1'b1;
        no_ack = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack) no_ack++;
        end
        check("mid_rst_no_ack", 32'(no_ack), 32'd0);
        txn(1'b0, 16'h000A, 16'h0000, 1'b0, 16'h5555, "ld_idx5", 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
